// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: produces PC / pipeline-register enables and flushes
// for load-use, branch, multi-cycle ALU and data-memory stalls, and counts stalled cycles.
module pipe_ctrl #(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_memread,
    input  logic            ex_branch_taken,
    input  logic            ex_div_start,
    input  logic            div_done,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic [1:0]      state,
    output logic [CNTW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } ctrl_t;

    typedef struct packed {
        ctrl_t  ctrl;
        state_t nxt;
    } decision_t;

    localparam ctrl_t CTRL_OFF      = ctrl_t'(8'b00000_000);
    localparam ctrl_t CTRL_ADVANCE  = ctrl_t'(8'b11111_000);
    localparam ctrl_t CTRL_FREEZE   = ctrl_t'(8'b00000_000);
    localparam ctrl_t CTRL_DIV      = ctrl_t'(8'b00011_001);
    localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b11111_110);
    localparam ctrl_t CTRL_LOADUSE  = ctrl_t'(8'b00111_010);

    // Priority resolution shared by RUN and by the release cycle of either wait state;
    // the caller masks the stall terms that no longer apply.
    function automatic decision_t eval_run(
        input logic mem_term,
        input logic div_term,
        input logic branch,
        input logic load_use
    );
        decision_t d;
        d.ctrl = CTRL_ADVANCE;
        d.nxt  = RUN;
        if (mem_term) begin
            d.ctrl = CTRL_FREEZE;
            d.nxt  = MEM_WAIT;
        end else if (div_term) begin
            d.ctrl = CTRL_DIV;
            d.nxt  = DIV_WAIT;
        end else if (branch) begin
            d.ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            d.ctrl = CTRL_LOADUSE;
        end
        return d;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    state_t          state_q;
    logic            load_use;
    logic            mem_term;
    logic            div_term;
    decision_t       dec;
    ctrl_t           ctrl;
    logic [CNTW-1:0] cnt_q;

    always_comb begin
        load_use = ex_memread && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
        mem_term = mem_req && !mem_ready;
        div_term = ex_div_start && !div_done;
        dec = eval_run(mem_term, div_term, ex_branch_taken, load_use);

        // Branches and load-use wait behind a frozen pipeline until the stall releases.
        case (state_q)
            MEM_WAIT: begin
                if (!mem_ready) begin
                    dec.ctrl = CTRL_FREEZE;
                    dec.nxt  = MEM_WAIT;
                end else begin
                    dec = eval_run(1'b0, div_term, ex_branch_taken, load_use);
                end
            end
            DIV_WAIT: begin
                if (!div_done) begin
                    dec.ctrl = CTRL_DIV;
                    dec.nxt  = DIV_WAIT;
                end else begin
                    dec = eval_run(1'b0, 1'b0, ex_branch_taken, load_use);
                end
            end
            default: ;
        endcase

        ctrl = rst ? CTRL_OFF : dec.ctrl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= dec.nxt;
            if (!ctrl.pc_en) begin
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign state       = state_q;
    assign stall_cnt   = cnt_q;

endmodule
